sr_cmd_driver: RTL and testbench

//   Command-side driver for a bank of N gated SR flip-flops. It accepts SET/CLEAR/TOGGLE/NOP requests over a

---
 rtl/sr_cmd_pkg.sv | 36 +++
 rtl/sr_cmd_driver_if.sv | 22 ++
 rtl/sr_fb_sync.sv | 22 ++
 rtl/sr_cmd_driver.sv | 154 +++++++++++++++
 tb/tb_sr_cmd_driver.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared encodings and small helpers for the SR command driver.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_SET = 2'b01,
    CMD_CLR = 2'b10,
    CMD_TGL = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BAD_IDX = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_INVALID = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Context latched at accept and carried to the response.
  typedef struct packed {
    logic target;
    err_e err;
  } ctx_t;

  // Counter width able to hold values 0..max_val, never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_cmd_driver_if.sv
// Request/response handshake between control logic and the SR command driver.
interface sr_cmd_driver_if #(
  parameter int unsigned IDX_W = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_cmd;
  logic [IDX_W-1:0] req_idx;
  logic             done;
  logic [1:0]       resp_err;
  logic             resp_q;

  modport master (
    output req_valid, req_cmd, req_idx,
    input  req_ready, done, resp_err, resp_q
  );

  modport slave (
    input  req_valid, req_cmd, req_idx,
    output req_ready, done, resp_err, resp_q
  );
endinterface

// File: rtl/sr_fb_sync.sv
// N-bit two-flop synchroniser for flop-bank feedback.
module sr_fb_sync #(
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  // Two register stages; reset clears both.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sr_cmd_driver.sv
// Drives exclusive S/R pulses into an SR flop bank and confirms the result via feedback.
module sr_cmd_driver
  import sr_cmd_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 8,
  parameter int unsigned IDX_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  sr_cmd_driver_if.slave bus,
  output logic [N-1:0] S,
  output logic [N-1:0] R,
  input  logic [N-1:0] Q,
  input  logic [N-1:0] Qn
);

  localparam int unsigned PW = cnt_width(PULSE_CYCLES);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  state_e        state;
  ctx_t          ctx;
  logic [N-1:0]  sel;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [N-1:0]  qs;
  logic [N-1:0]  qns;

  cmd_e          cmd_c;
  logic [N-1:0]  acc_mask_c;
  logic          bad_idx_c;
  logic          target_c;
  logic          qs_sel_c;
  logic          qns_sel_c;

  sr_fb_sync #(.W(N)) u_sync_q (
    .CLK  (CLK),
    .RST_N(RST_N),
    .d    (Q),
    .q    (qs)
  );

  sr_fb_sync #(.W(N)) u_sync_qn (
    .CLK  (CLK),
    .RST_N(RST_N),
    .d    (Qn),
    .q    (qns)
  );

  // Decode the incoming request and select feedback bits; shifts avoid out-of-range indexing.
  always_comb begin
    cmd_c      = cmd_e'(bus.req_cmd);
    acc_mask_c = N'(1) << bus.req_idx;
    bad_idx_c  = (32'(bus.req_idx) >= N);
    qs_sel_c   = |(qs & sel);
    qns_sel_c  = |(qns & sel);
    target_c   = 1'b0;
    case (cmd_c)
      CMD_SET: target_c = 1'b1;
      CMD_CLR: target_c = 1'b0;
      CMD_TGL: target_c = ~(|(qs & acc_mask_c));
      default: target_c = 1'b0;
    endcase
  end

  // Command FSM with registered S/R, handshake and response outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      ctx           <= '{target: 1'b0, err: ERR_OK};
      sel           <= '0;
      pcnt          <= '0;
      tcnt          <= '0;
      S             <= '0;
      R             <= '0;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.resp_err  <= 2'b00;
      bus.resp_q    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            pcnt          <= '0;
            tcnt          <= '0;
            ctx.target    <= target_c;
            if (cmd_c == CMD_NOP) begin
              sel     <= acc_mask_c;
              ctx.err <= ERR_OK;
              state   <= ST_RESP;
            end else if (bad_idx_c) begin
              sel     <= '0;
              ctx.err <= ERR_BAD_IDX;
              state   <= ST_RESP;
            end else begin
              sel     <= acc_mask_c;
              ctx.err <= ERR_OK;
              S       <= target_c ? acc_mask_c : '0;
              R       <= target_c ? '0 : acc_mask_c;
              state   <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE: begin
          if (pcnt >= PW'(PULSE_CYCLES - 1)) begin
            S     <= '0;
            R     <= '0;
            tcnt  <= '0;
            state <= ST_CHECK;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end

        ST_CHECK: begin
          S <= '0;
          R <= '0;
          if (qs_sel_c == qns_sel_c) begin
            ctx.err <= ERR_INVALID;
            state   <= ST_RESP;
          end else if (qs_sel_c == ctx.target) begin
            ctx.err <= ERR_OK;
            state   <= ST_RESP;
          end else if (tcnt >= TW'(TIMEOUT - 1)) begin
            ctx.err <= ERR_TIMEOUT;
            state   <= ST_RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        ST_RESP: begin
          bus.done      <= 1'b1;
          bus.resp_err  <= ctx.err;
          bus.resp_q    <= qs_sel_c;
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end

        default: begin
          S             <= '0;
          R             <= '0;
          bus.req_ready <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver with a behavioural gated-SR flop bank.
module tb_sr_cmd_driver;
  import sr_cmd_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned PC    = 2;
  localparam int unsigned TO    = 8;
  localparam int unsigned IDX_W = 3;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [N-1:0] S, R, Q, Qn;
  logic [N-1:0] q_bank = '0;
  logic [N-1:0] fq_en = '0, fq_val = '0, fqn_val = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic sr_acc = 1'b0;
  logic [N-1:0] model = '0;

  sr_cmd_driver_if #(.IDX_W(IDX_W)) bus ();

  sr_cmd_driver #(.N(N), .PULSE_CYCLES(PC), .TIMEOUT(TO), .IDX_W(IDX_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus),
    .S    (S),
    .R    (R),
    .Q    (Q),
    .Qn   (Qn)
  );

  always #5 CLK = ~CLK;

  // Gated SR flop bank: transparent while CLK is high.
  always @(CLK or S or R) if (CLK) q_bank = (q_bank | S) & ~R;

  assign Q  = (q_bank & ~fq_en) | (fq_val & fq_en);
  assign Qn = (~q_bank & ~fq_en) | (fqn_val & fq_en);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    chk("sr_exclusive", 32'(S & R), 32'd0);
    chk("sr_onehot0", 32'($onehot0(S | R)), 32'd1);
    sr_acc = sr_acc | (|(S | R));
  endtask

  task automatic send(input logic [1:0] cmd, input logic [IDX_W-1:0] idx);
    chk("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_idx   = idx;
    sr_acc        = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    acc_cyc       = cyc;
    chk("ready_after_accept", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [1:0] exp_err,
                           input logic exp_q);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
      chk({tag, "_q"}, 32'(bus.resp_q), 32'(exp_q));
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_idx   = '0;

    // Reset state
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_q", 32'(bus.resp_q), 32'd0);
    chk("rst_s", 32'(S), 32'd0);
    chk("rst_r", 32'(R), 32'd0);

    // 1. SET idx 2: two S pulse cycles, done 4 cycles after accept
    send(CMD_SET, 3'd2);
    chk("set_s_c1", 32'(S), 32'h4);
    chk("set_r_c1", 32'(R), 32'h0);
    tick();
    chk("set_s_c2", 32'(S), 32'h4);
    tick();
    chk("set_s_off", 32'(S), 32'h0);
    wait_done("set2", PC + 2, ERR_OK, 1'b1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("resp_err_held", 32'(bus.resp_err), 32'd0);
    chk("resp_q_held", 32'(bus.resp_q), 32'd1);

    // 2. CLEAR idx 2 then TOGGLE idx 2 back-to-back
    send(CMD_CLR, 3'd2);
    chk("clr_r", 32'(R), 32'h4);
    chk("clr_s", 32'(S), 32'h0);
    wait_done("clr2", PC + 2, ERR_OK, 1'b0);
    chk("b2b_ready", 32'(bus.req_ready), 32'd1);
    send(CMD_TGL, 3'd2);
    chk("tgl_s", 32'(S), 32'h4);
    chk("tgl_r", 32'(R), 32'h0);
    wait_done("tgl2", PC + 2, ERR_OK, 1'b1);

    // 3. NOP then out-of-range index: single-cycle response, nothing driven
    send(CMD_NOP, 3'd2);
    wait_done("nop", 1, ERR_OK, 1'b1);
    chk("nop_no_sr", 32'(sr_acc), 32'd0);
    send(CMD_SET, 3'd5);
    wait_done("badidx", 1, ERR_BAD_IDX, 1'b0);
    chk("badidx_no_sr", 32'(sr_acc), 32'd0);

    // 4. Q[1]/Qn[1] stuck at 0/1: SET idx 1 times out
    fq_en = 4'b0010; fq_val = 4'b0000; fqn_val = 4'b0010;
    repeat (3) tick();
    send(CMD_SET, 3'd1);
    wait_done("timeout", PC + TO + 1, ERR_TIMEOUT, 1'b0);
    fq_en = '0;

    // 5. Q[0]=Qn[0]=1: CLEAR idx 0 reports INVALID at the first check
    fq_en = 4'b0001; fq_val = 4'b0001; fqn_val = 4'b0001;
    repeat (3) tick();
    send(CMD_CLR, 3'd0);
    wait_done("invalid", PC + 2, ERR_INVALID, 1'b1);
    fq_en = '0;
    repeat (3) tick();

    // 6. Reset during DRIVE: outputs drop at that edge, no done afterwards
    send(CMD_SET, 3'd3);
    chk("pre_rst_s", 32'(S), 32'h8);
    RST_N = 1'b0;
    tick();
    chk("midrst_s", 32'(S), 32'h0);
    chk("midrst_r", 32'(R), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("postrst_ready", 32'(bus.req_ready), 32'd1);
    sr_acc = 1'b0;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (12) begin
        tick();
        seen_done = seen_done | bus.done;
      end
      chk("postrst_no_done", 32'(seen_done), 32'd0);
      chk("postrst_no_sr", 32'(sr_acc), 32'd0);
    end

    // Clear the whole bank so the model starts from a known state
    for (int i = 0; i < int'(N); i++) begin
      send(CMD_CLR, IDX_W'(i));
      wait_done("init_clr", PC + 2, ERR_OK, 1'b0);
    end
    model = '0;

    // Random legal requests against a reference model of the bank
    for (int k = 0; k < 24; k++) begin
      logic [1:0] cmd;
      int idx;
      cmd = 2'($urandom_range(0, 3));
      idx = int'($urandom_range(0, N - 1));
      case (cmd)
        2'b01:   model[idx] = 1'b1;
        2'b10:   model[idx] = 1'b0;
        2'b11:   model[idx] = ~model[idx];
        default: ;
      endcase
      send(cmd, IDX_W'(idx));
      wait_done("rand", (cmd == 2'b00) ? 1 : int'(PC) + 2, ERR_OK, model[idx]);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
